// File: rtl/rgb_pwm_ctrl_pkg.sv
// Shared types and constants for the RGB PWM controller:
// FSM state enum, mode codes, register addresses, channel count and
// blink counter width.
package rgb_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_STEADY    = 2'd1,
    ST_BLINK_ON  = 2'd2,
    ST_BLINK_OFF = 2'd3
  } state_e;

  // mode register bits [1:0]
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;  // decoded as OFF

  // register select
  localparam logic [1:0] ADDR_BLUE  = 2'd0;
  localparam logic [1:0] ADDR_GREEN = 2'd1;
  localparam logic [1:0] ADDR_RED   = 2'd2;
  localparam logic [1:0] ADDR_MODE  = 2'd3;

  localparam int NUM_CH = 3;
  // (63+1) * 65535 frames fits in 22 bits
  localparam int BLINK_CNT_W = 22;

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Register-write command bus for rgb_pwm_ctrl.
//   cmd_valid : requester presents a write
//   cmd_ready : block accepts the write
//   cmd_addr  : 0 blue, 1 green, 2 red, 3 mode
//   cmd_data  : write data
interface rgb_pwm_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/rgb_pwm_ctrl_pwm_channel.sv
// One PWM lane: output is high when duty > phase, registered once.
//   clk, rst : clock, synchronous active-high reset
//   en       : lane enable (low forces the output low)
//   duty     : active duty value
//   phase    : shared PWM phase counter
//   pwm      : registered PWM output
module pwm_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty,
  input  logic [7:0] phase,
  output logic       pwm
);
  logic pwm_d, pwm_q;

  always_comb pwm_d = en && (duty > phase);

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED PWM controller with double-buffered registers and blink FSM.
// Writes land in staging registers; all four are copied to the active set
// on frame_end so colour/mode changes never tear mid-frame.
//   clk, rst   : clock, synchronous active-high reset
//   cmd        : register write bus (slave side)
//   rgb0_pwm   : blue PWM      rgb1_pwm : green PWM    rgb2_pwm : red PWM
//   led_en     : LED driver enable
//   frame_end  : one-cycle pulse at every PWM frame boundary
module rgb_pwm_ctrl
  import rgb_pwm_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 47,
  parameter int BLINK_UNIT = 64
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_ctrl_if.slave  cmd,
  output logic           rgb0_pwm,
  output logic           rgb1_pwm,
  output logic           rgb2_pwm,
  output logic           led_en,
  output logic           frame_end
);
  logic [15:0]            presc_q, presc_d;
  logic [7:0]             phase_q, phase_d;
  logic [3:0][7:0]        stage_q, stage_d;
  logic [3:0][7:0]        act_q, act_d;
  state_e                 state_q, state_d;
  logic [BLINK_CNT_W-1:0] bcnt_q, bcnt_d, bcnt_inc, blim;
  logic                   tick, fe, wr_en, pwm_en;
  logic [NUM_CH-1:0]      pwm;

  assign cmd.cmd_ready = ~rst;
  assign wr_en         = cmd.cmd_valid & cmd.cmd_ready;

  // timebase, staging and commit
  always_comb begin
    tick    = (presc_q == 16'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 16'd1;
    phase_d = tick ? phase_q + 8'd1 : phase_q;
    fe      = tick && (phase_q == 8'hFF);
    stage_d = stage_q;
    if (wr_en) stage_d[cmd.cmd_addr] = cmd.cmd_data;
    // commit from stage_d so a write on the frame_end cycle is included
    act_d = fe ? stage_d : act_q;
  end

  // FSM: decisions use the just-committed mode (act_d)
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bcnt_inc = bcnt_q + BLINK_CNT_W'(1);
    blim     = BLINK_CNT_W'({1'b0, act_d[ADDR_MODE][7:2]} + 7'd1)
             * BLINK_CNT_W'(BLINK_UNIT);
    if (fe) begin
      case (act_d[ADDR_MODE][1:0])
        MODE_STEADY: state_d = ST_STEADY;
        MODE_BLINK: begin
          if (state_q == ST_BLINK_ON || state_q == ST_BLINK_OFF) begin
            // >= so a shrunk H toggles at once without restarting the count
            if (bcnt_inc >= blim) begin
              state_d = (state_q == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
              bcnt_d  = '0;
            end else begin
              bcnt_d  = bcnt_inc;
            end
          end else begin
            state_d = ST_BLINK_ON;
            bcnt_d  = '0;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      phase_q <= '0;
      stage_q <= '0;
      act_q   <= '0;
      state_q <= ST_OFF;
      bcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      stage_q <= stage_d;
      act_q   <= act_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign pwm_en = (state_q == ST_STEADY) || (state_q == ST_BLINK_ON);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (pwm_en),
      .duty  (act_q[i]),
      .phase (phase_q),
      .pwm   (pwm[i])
    );
  end

  assign rgb0_pwm  = pwm[0];
  assign rgb1_pwm  = pwm[1];
  assign rgb2_pwm  = pwm[2];
  assign led_en    = (state_q != ST_OFF);
  assign frame_end = fe;
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
module tb_rgb_pwm_ctrl;
  logic clk, rst;
  logic rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, frame_end;
  int total, bad;

  typedef struct {
    bit led;
    int c0, c1, c2;
  } frame_t;
  frame_t exp_q[$];

  rgb_pwm_ctrl_if bus();

  rgb_pwm_ctrl #(.PRESCALE(1), .BLINK_UNIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .rgb0_pwm  (rgb0_pwm),
    .rgb1_pwm  (rgb1_pwm),
    .rgb2_pwm  (rgb2_pwm),
    .led_en    (led_en),
    .frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input bit led, input int c0, input int c1, input int c2);
    frame_t f;
    f.led = led; f.c0 = c0; f.c1 = c1; f.c2 = c2;
    exp_q.push_back(f);
  endtask

  // wait (bounded) until a frame_end cycle, sampled at negedge
  task automatic sync_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_end !== 1'b1 && n < 600);
    total++;
    if (frame_end !== 1'b1) begin
      bad++;
      $display("FAIL %s sync: frame_end not seen in %0d cycles", tag, n);
    end
  endtask

  // Observe the 256 cycles after a frame_end (ending on the next frame_end),
  // optionally issuing one write at cycle wr_at, then score against exp_q.
  task automatic measure(input bit wr, input int wr_at, input logic [1:0] a,
                         input logic [7:0] d, input string tag);
    int c0 = 0, c1 = 0, c2 = 0, lh = 0, fe = 0;
    bit fe_last = 0;
    frame_t e;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c0 += int'(rgb0_pwm); c1 += int'(rgb1_pwm); c2 += int'(rgb2_pwm);
      lh += int'(led_en);   fe += int'(frame_end);
      if (i == 255) fe_last = frame_end;
      if (wr && i == wr_at) begin
        bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_data = d;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    if (bus.cmd_valid) begin
      @(posedge clk); #1 bus.cmd_valid = 1'b0;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got frame, want none queued", tag);
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (lh !== (e.led ? 256 : 0)) begin
      bad++; $display("FAIL %s led_en: got %0d high cycles want %0d", tag, lh, e.led ? 256 : 0);
    end
    total++;
    if (c0 !== e.c0) begin
      bad++; $display("FAIL %s rgb0: got %0d want %0d", tag, c0, e.c0);
    end
    total++;
    if (c1 !== e.c1) begin
      bad++; $display("FAIL %s rgb1: got %0d want %0d", tag, c1, e.c1);
    end
    total++;
    if (c2 !== e.c2) begin
      bad++; $display("FAIL %s rgb2: got %0d want %0d", tag, c2, e.c2);
    end
    total++;
    if (fe !== 1 || fe_last !== 1'b1) begin
      bad++; $display("FAIL %s frame_end: got count %0d last %0d want 1 1", tag, fe, fe_last);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b0 || led_en !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got ready=%b led=%b want 0 0", bus.cmd_ready, led_en);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.cmd_ready, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, frame_end} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_exit: got %b want 100000",
               {bus.cmd_ready, rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, frame_end});
    end
  endtask

  task automatic test_steady;
    sync_frame("steady");
    push(0, 0, 0, 0);  measure(1, 5, 2'd0, 8'd64, "steady_wr_duty");
    push(0, 0, 0, 0);  measure(1, 20, 2'd3, 8'h01, "steady_wr_mode");
    push(1, 64, 0, 0); measure(0, 0, 2'd0, 8'd0, "steady_f1");
    push(1, 64, 0, 0); measure(0, 0, 2'd0, 8'd0, "steady_f2");
  endtask

  task automatic test_commit_edge;
    push(1, 64, 0, 0);   measure(1, 255, 2'd2, 8'h80, "edge_wr");
    push(1, 64, 0, 128); measure(0, 0, 2'd0, 8'd0, "edge_applied");
  endtask

  task automatic test_commit_late;
    push(1, 64, 0, 128); measure(1, 0, 2'd2, 8'h20, "late_wr");
    push(1, 64, 0, 32);  measure(0, 0, 2'd0, 8'd0, "late_applied");
  endtask

  task automatic test_extremes;
    push(1, 64, 0, 32);  measure(1, 3, 2'd0, 8'd0, "ext_wr0");
    push(1, 0, 0, 32);   measure(1, 9, 2'd1, 8'd255, "ext_wr255");
    push(1, 0, 255, 32); measure(0, 0, 2'd0, 8'd0, "ext_check");
  endtask

  task automatic test_blink;
    push(1, 0, 255, 32); measure(1, 50, 2'd3, 8'h06, "blink_wr");
    for (int k = 0; k < 8; k++) begin
      if (k < 4) push(1, 0, 255, 32);
      else       push(1, 0, 0, 0);
      measure(0, 0, 2'd0, 8'd0, (k < 4) ? "blink_on" : "blink_off");
    end
  endtask

  // now in BLINK_ON; stage a write then reset before it can commit
  task automatic test_reset_mid;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_data = 8'h11;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    total++;
    if (led_en !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: got led=%b want 1", led_en);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_ready: got %b want 0", bus.cmd_ready);
    end
    @(negedge clk);
    total++;
    if ({rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, frame_end} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_out: got %b want 00000",
               {rgb0_pwm, rgb1_pwm, rgb2_pwm, led_en, frame_end});
    end
    rst = 1'b0;
    sync_frame("rstmid");
    push(0, 0, 0, 0); measure(1, 5, 2'd3, 8'h01, "rstmid_mode");
    push(1, 0, 0, 0); measure(0, 0, 2'd0, 8'd0, "rstmid_nostale");
  endtask

  task automatic test_mode3;
    push(1, 0, 0, 0);  measure(1, 7, 2'd0, 8'h40, "m3_duty");
    push(1, 64, 0, 0); measure(1, 7, 2'd3, 8'h03, "m3_wr");
    push(0, 0, 0, 0);  measure(0, 0, 2'd0, 8'd0, "m3_off");
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = 2'd0; bus.cmd_data = 8'd0;
    test_reset();
    test_steady();
    test_commit_edge();
    test_commit_late();
    test_extremes();
    test_blink();
    test_reset_mid();
    test_mode3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
